// File: rtl/wb_uart.sv
// Wishbone B3 slave UART: 8N1 transmitter fed by a small TX FIFO, receiver with a
// one-byte holding register, programmable bit period and a level interrupt.
module wb_uart #(
    parameter logic [15:0] DIV_RST    = 16'd650,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        uart_int_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

    logic        ack_q, ack_d, int_q, int_d;
    logic [31:0] dat_q, dat_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d, div_eff;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d, overrun_q, overrun_d, ferr_q, ferr_d;

    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, push, tx_pop, tx_empty;

    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d, tx_tick;

    state_e      rx_state_q, rx_state_d;
    logic [2:0]  rx_sync_q, rx_sync_d;
    logic [16:0] rx_cnt_q, rx_cnt_d, rx_period;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_in, rx_fall, rx_tick, rx_done, rx_ferr;

    logic        ack_req, wr_en, rd_en;
    logic [1:0]  reg_sel;
    logic        unused_bits;

    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:1]};

    assign ack_req = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en   = ack_req & wb_we_i & wb_sel_i[0];
    assign rd_en   = ack_req & ~wb_we_i;
    assign reg_sel = wb_adr_i[3:2];
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign tx_tick    = (tx_cnt_q == 16'd0);
    assign tx_pop     = ~fifo_empty & ((tx_state_q == ST_IDLE) | ((tx_state_q == ST_STOP) & tx_tick));
    assign push       = wr_en & (reg_sel == 2'd0) & (~fifo_full | tx_pop);
    assign tx_empty   = fifo_empty & (tx_state_q == ST_IDLE);
    assign wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
    assign rd_ptr_d   = rd_ptr_q + (AW+1)'(tx_pop);

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= wb_dat_i[7:0];
    end

    // TX next state: each state holds for div_eff+1 clocks, reloading from the live divisor.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            ST_IDLE: if (tx_pop) begin
                tx_state_d = ST_START;
                tx_cnt_d   = div_eff;
                tx_shift_d = fifo_q[rd_ptr_q[AW-1:0]];
            end
            ST_START: if (tx_tick) begin
                tx_state_d = ST_DATA;
                tx_cnt_d   = div_eff;
                tx_bit_d   = 3'd0;
            end else tx_cnt_d = tx_cnt_q - 16'd1;
            ST_DATA: if (tx_tick) begin
                tx_cnt_d = div_eff;
                if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end
            end else tx_cnt_d = tx_cnt_q - 16'd1;
            ST_STOP: if (tx_tick) begin
                tx_state_d = tx_pop ? ST_START : ST_IDLE;
                tx_cnt_d   = div_eff;
                if (tx_pop) tx_shift_d = fifo_q[rd_ptr_q[AW-1:0]];
            end else tx_cnt_d = tx_cnt_q - 16'd1;
            default: tx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (tx_state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = tx_shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // RX: two synchroniser stages plus one history flop for edge detection.
    assign rx_sync_d = {rx_sync_q[1:0], uart_rxd};
    assign rx_in     = rx_sync_q[1];
    assign rx_fall   = rx_sync_q[2] & ~rx_sync_q[1];
    assign rx_period = {1'b0, div_eff} + 17'd1;
    assign rx_tick   = (rx_cnt_q == 17'd1);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            ST_IDLE: if (rx_fall) begin
                rx_state_d = ST_START;
                rx_cnt_d   = rx_period >> 1;
            end
            ST_START: if (rx_tick) begin
                rx_state_d = rx_in ? ST_IDLE : ST_DATA;
                rx_cnt_d   = rx_period;
                rx_bit_d   = 3'd0;
            end else rx_cnt_d = rx_cnt_q - 17'd1;
            ST_DATA: if (rx_tick) begin
                rx_shift_d = {rx_in, rx_shift_q[7:1]};
                rx_cnt_d   = rx_period;
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
            end else rx_cnt_d = rx_cnt_q - 17'd1;
            ST_STOP: if (rx_tick) rx_state_d = ST_IDLE;
                     else rx_cnt_d = rx_cnt_q - 17'd1;
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_done = 1'b0;
        rx_ferr = 1'b0;
        if (rx_state_q == ST_STOP && rx_tick) begin
            rx_done = rx_in;
            rx_ferr = ~rx_in;
        end
    end

    // Register file and status flags; set events take priority over read-clears.
    always_comb begin
        ctrl_d     = ctrl_q;
        div_d      = div_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        ferr_d     = ferr_q;
        dat_d      = '0;
        if (rd_en) begin
            case (reg_sel)
                2'd0: begin
                    dat_d      = {24'b0, rx_byte_q};
                    rx_valid_d = 1'b0;
                end
                2'd1: begin
                    dat_d     = {27'b0, ferr_q, overrun_q, tx_empty, fifo_full, rx_valid_q};
                    overrun_d = 1'b0;
                    ferr_d    = 1'b0;
                end
                2'd2:    dat_d = {30'b0, ctrl_q};
                default: dat_d = {16'b0, div_q};
            endcase
        end
        if (wr_en && reg_sel == 2'd2) ctrl_d = wb_dat_i[1:0];
        if (wr_en && reg_sel == 2'd3) div_d  = wb_dat_i[15:0];
        if (rx_done) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !(rd_en && reg_sel == 2'd0)) overrun_d = 1'b1;
        end
        if (rx_ferr) ferr_d = 1'b1;
        ack_d = ack_req;
        int_d = (ctrl_q[0] & rx_valid_q) | (ctrl_q[1] & tx_empty) | overrun_q | ferr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            int_q      <= 1'b0;
            ctrl_q     <= '0;
            div_q      <= DIV_RST;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_sync_q  <= 3'b111;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            int_q      <= int_d;
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_sync_q  <= rx_sync_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign uart_txd   = txd_q;
    assign uart_int_o = int_q;
endmodule

// File: tb/tb_wb_uart.sv
// Directed self-checking bench for wb_uart: register access, TX framing and streaming,
// loopback receive, overrun, framing error and mid-frame reset.
module tb_wb_uart;
    localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_DIV = 2'd3;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat_w = '0, dat_r;
    logic [3:0]  sel = '0;
    logic        ack, txd, irq, rxd;
    logic        rxd_drv = 1'b1, loop = 1'b0;
    int          n_cmp = 0, n_err = 0;
    bit          cap [0:511];

    assign rxd = loop ? txd : rxd_drv;

    wb_uart dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_w), .wb_dat_o(dat_r), .wb_ack_o(ack),
        .uart_rxd(rxd), .uart_txd(txd), .uart_int_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line samples for one 8N1 frame, one sample per clock, start bit first.
    function automatic logic [63:0] frame_bits(input logic [7:0] b, input int per);
        logic [63:0] r;
        int k;
        r = '0;
        for (int i = 0; i < 10 * per; i++) begin
            k = i / per;
            r[i] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        end
        return r;
    endfunction

    function automatic logic [63:0] cap_bits(input int start, input int per);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 10 * per; i++) r[i] = cap[start+i];
        return r;
    endfunction

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] r, output int lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = {28'h0, a, 2'b00}; sel = 4'hF; dat_w = d;
        lat = 0;
        r = '0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                r = dat_r;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        int lat;
        bus(1'b1, a, d, r, lat);
        check("wr_ack_lat", lat, 1);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        int lat;
        bus(1'b0, a, '0, r, lat);
        check({tag, "_lat"}, lat, 1);
        check(tag, r, exp);
    endtask

    // Waits (bounded) for the start bit, then records n consecutive per-clock line samples.
    task automatic capture(input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (txd == 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        check("tx_start_seen", seen, 1);
        cap[0] = txd;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            cap[i] = txd;
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int per);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd_drv = f[k];
            repeat (per) @(negedge clk);
        end
    endtask

    initial begin
        repeat (300000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks;
        bit got_irq;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_dat_o", dat_r, 0);
        check("rst_txd", txd, 1);
        check("rst_int", irq, 0);
        rd_chk("rst_DATA", A_DATA, 32'h0);
        rd_chk("rst_STATUS", A_STAT, 32'h4);
        rd_chk("rst_CTRL", A_CTRL, 32'h0);
        rd_chk("rst_DIV", A_DIV, 32'd650);

        // Strobe held for four clocks: acknowledged every second cycle.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {28'h0, A_CTRL, 2'b00};
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("b2b_acks", acks, 2);

        // Single frame 0xA5 at four clocks per bit.
        wr(A_DIV, 32'd3);
        wr(A_DATA, 32'hA5);
        fork
            capture(40);
            begin
                repeat (8) @(negedge clk);
                rd_chk("busy_STATUS", A_STAT, 32'h0);
            end
        join
        check("A5_frame", cap_bits(0, 4), frame_bits(8'hA5, 4));
        rd_chk("A5_idle_STATUS", A_STAT, 32'h4);
        check("A5_txd_idle", txd, 1);

        // Divisor 0 behaves as 1: two clocks per bit.
        wr(A_DIV, 32'd0);
        rd_chk("div0_readback", A_DIV, 32'd0);
        wr(A_DATA, 32'h96);
        capture(20);
        check("div0_frame", cap_bits(0, 2), frame_bits(8'h96, 2));
        repeat (4) @(negedge clk);
        wr(A_DIV, 32'd3);

        // Nine bytes fill the pipe (one in flight, eight queued); a tenth is dropped.
        fork
            capture(400);
            begin
                for (int i = 1; i <= 9; i++) wr(A_DATA, i);
                rd_chk("full_STATUS", A_STAT, 32'h2);
                wr(A_DATA, 32'h0A);
            end
        join
        for (int f = 0; f < 9; f++)
            check($sformatf("stream_f%0d", f), cap_bits(f * 40, 4), frame_bits(8'(f + 1), 4));
        check("stream_no_10th", cap_bits(360, 4), 64'h00FF_FFFF_FFFF);
        rd_chk("stream_end_STATUS", A_STAT, 32'h4);

        // Loopback receive with rx_ie set.
        wr(A_CTRL, 32'h1);
        loop = 1'b1;
        wr(A_DATA, 32'h3C);
        got_irq = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (irq) begin
                got_irq = 1'b1;
                break;
            end
        end
        check("lb_int", got_irq, 1);
        repeat (8) @(negedge clk);
        rd_chk("lb_STATUS", A_STAT, 32'h5);
        rd_chk("lb_DATA", A_DATA, 32'h3C);
        repeat (2) @(negedge clk);
        check("lb_int_clear", irq, 0);
        rd_chk("lb_after_STATUS", A_STAT, 32'h4);
        loop = 1'b0;

        // Two frames without reading: overrun, last byte kept, overrun cleared by STATUS read.
        rx_frame(8'h11, 1'b1, 4);
        rx_frame(8'h22, 1'b1, 4);
        repeat (8) @(negedge clk);
        check("ovr_int", irq, 1);
        rd_chk("ovr_STATUS", A_STAT, 32'hD);
        rd_chk("ovr_DATA", A_DATA, 32'h22);
        rd_chk("ovr_STATUS2", A_STAT, 32'h4);

        // Framing error, then reset in the middle of the next frame with TX busy.
        wr(A_CTRL, 32'h0);
        rx_frame(8'h55, 1'b0, 4);
        rxd_drv = 1'b1;
        repeat (8) @(negedge clk);
        check("ferr_int", irq, 1);
        wr(A_DATA, 32'hF0);
        rxd_drv = 1'b0;
        repeat (10) @(negedge clk);
        rxd_drv = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_int", irq, 0);
        check("mid_rst_ack", ack, 0);
        rd_chk("mid_rst_STATUS", A_STAT, 32'h4);
        rd_chk("mid_rst_CTRL", A_CTRL, 32'h0);
        rd_chk("mid_rst_DIV", A_DIV, 32'd650);
        rd_chk("mid_rst_DATA", A_DATA, 32'h0);
        repeat (60) @(negedge clk);
        check("mid_rst_txd_quiet", txd, 1);

        // Receiver starts cleanly from IDLE after the reset.
        wr(A_DIV, 32'd3);
        rx_frame(8'h5A, 1'b1, 4);
        repeat (8) @(negedge clk);
        rd_chk("post_rst_STATUS", A_STAT, 32'h5);
        rd_chk("post_rst_DATA", A_DATA, 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
